set24_time_editor: RTL and testbench

Sequencing controller for manual 24-hour time setting. It snapshots the running clock on request and walks the user through hour then minute editing with increment/decrement buttons, auto-repeat and blinking of the field being edited. It drives the hours/minutes inputs of the set-24 display decoder and emits a one-cycle commit to the timekeeper. Display order is fixed: disp0/1 = hour tens/units, disp2/3 = minute tens/units, disp4/5 = 0.

---
 rtl/set24_time_editor.sv | 152 +++++++++++++++
 tb/tb_set24_time_editor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/set24_time_editor.sv
// Manual 24-hour time editor: snapshots the running time, steps hours then minutes
// with inc/dec auto-repeat and field blinking, and pulses commit with the new time.
module set24_time_editor #(
    parameter int unsigned BLINK_HALF   = 25_000_000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000,
    parameter int unsigned TIMEOUT      = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_req,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] blank,
    output logic       editing,
    output logic       commit
);

    localparam int unsigned BW = $clog2(2 * BLINK_HALF);
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] EDIT_HOUR = 2'd1;
    localparam logic [1:0] EDIT_MIN  = 2'd2;
    localparam logic [1:0] COMMIT    = 2'd3;

    logic [1:0]    state, state_n;
    logic [4:0]    hours_n;
    logic [5:0]    minutes_n, blank_n;
    logic          editing_n, commit_n;
    logic          prev_next, prev_inc, prev_dec;
    logic          inc_armed, inc_armed_n, dec_armed, dec_armed_n;
    logic [RW-1:0] inc_rcnt, inc_rcnt_n, dec_rcnt, dec_rcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          next_edge, inc_edge, dec_edge, inc_fire, dec_fire;
    logic          step_up, step_dn;

    // Edges are taken against last cycle's level, so a button held at entry never acts
    assign next_edge = btn_next & ~prev_next;
    assign inc_edge  = btn_inc & ~prev_inc;
    assign dec_edge  = btn_dec & ~prev_dec;
    assign inc_fire  = inc_edge | (inc_armed & btn_inc & (inc_rcnt == RW'(REPEAT_DELAY)));
    assign dec_fire  = dec_edge | (dec_armed & btn_dec & (dec_rcnt == RW'(REPEAT_DELAY)));

    always_comb begin
        state_n     = state;
        hours_n     = hours;
        minutes_n   = minutes;
        inc_armed_n = 1'b0;
        dec_armed_n = 1'b0;
        inc_rcnt_n  = '0;
        dec_rcnt_n  = '0;
        bcnt_n      = '0;
        tcnt_n      = '0;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        case (state)
            IDLE: begin
                if (set_req) begin
                    state_n   = EDIT_HOUR;
                    hours_n   = (cur_hours > 5'd23) ? 5'd0 : cur_hours;
                    minutes_n = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                end else begin
                    hours_n   = cur_hours;
                    minutes_n = cur_minutes;
                end
            end
            EDIT_HOUR, EDIT_MIN: begin
                if (set_req || (tcnt == TW'(TIMEOUT - 1))) begin
                    state_n = IDLE;
                end else if (next_edge) begin
                    state_n = (state == EDIT_HOUR) ? EDIT_MIN : COMMIT;
                end else begin
                    // Repeat counters reload so the next hit lands REPEAT_RATE later
                    inc_armed_n = inc_edge | (inc_armed & btn_inc);
                    dec_armed_n = dec_edge | (dec_armed & btn_dec);
                    inc_rcnt_n  = inc_edge ? RW'(1) : !inc_armed_n ? '0 :
                                  (inc_rcnt == RW'(REPEAT_DELAY)) ?
                                  RW'(REPEAT_DELAY - REPEAT_RATE + 1) : inc_rcnt + RW'(1);
                    dec_rcnt_n  = dec_edge ? RW'(1) : !dec_armed_n ? '0 :
                                  (dec_rcnt == RW'(REPEAT_DELAY)) ?
                                  RW'(REPEAT_DELAY - REPEAT_RATE + 1) : dec_rcnt + RW'(1);
                    step_up     = inc_fire & ~btn_dec;
                    step_dn     = dec_fire & ~btn_inc;
                    tcnt_n      = (inc_edge || dec_edge) ? '0 : tcnt + TW'(1);
                    bcnt_n      = (step_up || step_dn || (bcnt == BW'(2 * BLINK_HALF - 1))) ?
                                  '0 : bcnt + BW'(1);
                    if (state == EDIT_HOUR) begin
                        if (step_up)      hours_n = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                        else if (step_dn) hours_n = (hours == 5'd0) ? 5'd23 : hours - 5'd1;
                    end else begin
                        if (step_up)      minutes_n = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                        else if (step_dn) minutes_n = (minutes == 6'd0) ? 6'd59 : minutes - 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        editing_n = (state_n != IDLE);
        commit_n  = (state_n == COMMIT);
        blank_n   = '0;
        if (bcnt_n >= BW'(BLINK_HALF)) begin
            if (state_n == EDIT_HOUR)     blank_n = 6'b000011;
            else if (state_n == EDIT_MIN) blank_n = 6'b001100;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hours     <= '0;
            minutes   <= '0;
            blank     <= '0;
            editing   <= 1'b0;
            commit    <= 1'b0;
            prev_next <= 1'b0;
            prev_inc  <= 1'b0;
            prev_dec  <= 1'b0;
            inc_armed <= 1'b0;
            dec_armed <= 1'b0;
            inc_rcnt  <= '0;
            dec_rcnt  <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
        end else begin
            state     <= state_n;
            hours     <= hours_n;
            minutes   <= minutes_n;
            blank     <= blank_n;
            editing   <= editing_n;
            commit    <= commit_n;
            prev_next <= btn_next;
            prev_inc  <= btn_inc;
            prev_dec  <= btn_dec;
            inc_armed <= inc_armed_n;
            dec_armed <= dec_armed_n;
            inc_rcnt  <= inc_rcnt_n;
            dec_rcnt  <= dec_rcnt_n;
            bcnt      <= bcnt_n;
            tcnt      <= tcnt_n;
        end
    end

endmodule

// File: tb/tb_set24_time_editor.sv
// Bench for set24_time_editor: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_set24_time_editor;

    localparam int BH = 4;
    localparam int RD = 6;
    localparam int RR = 2;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset, set_req, btn_next, btn_inc, btn_dec;
    logic [4:0] cur_hours, hours;
    logic [5:0] cur_minutes, minutes, blank;
    logic       editing, commit;

    int vectors = 0;
    int miscompares = 0;

    set24_time_editor #(
        .BLINK_HALF(BH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .set_req(set_req), .btn_next(btn_next),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .cur_hours(cur_hours),
        .cur_minutes(cur_minutes), .hours(hours), .minutes(minutes),
        .blank(blank), .editing(editing), .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 hour field, 2 minute field, 3 commit.
    // Timing is tracked as cycle stamps of entry, last activity and button presses.
    int t = 0, mode = 0, mh = 0, mm = 0;
    int inc_press = -1, dec_press = -1, blink_ref = 0, act_ref = 0;
    bit p_next = 0, p_inc = 0, p_dec = 0;
    int eh = 0, em = 0, eblank = 0, eedit = 0, ecommit = 0;

    function automatic bit rep_hit(input int k);
        return (k == 0) || (k >= RD && ((k - RD) % RR) == 0);
    endfunction

    function automatic int bump(input int v, input int modulus, input bit up);
        return up ? (v + 1) % modulus : (v + modulus - 1) % modulus;
    endfunction

    always @(posedge clk) begin
        bit en, ei, ed, fi, fd;
        int nm;
        if (reset) begin
            mode = 0; mh = 0; mm = 0;
            p_next = 0; p_inc = 0; p_dec = 0;
            eblank = 0;
        end else begin
            en = btn_next && !p_next;
            ei = btn_inc && !p_inc;
            ed = btn_dec && !p_dec;
            nm = mode;
            if (mode == 0) begin
                if (set_req) begin
                    mh = (cur_hours > 23) ? 0 : int'(cur_hours);
                    mm = (cur_minutes > 59) ? 0 : int'(cur_minutes);
                    nm = 1;
                end else begin
                    mh = int'(cur_hours);
                    mm = int'(cur_minutes);
                end
            end else if (mode == 3) begin
                nm = 0;
            end else if (set_req || (t - act_ref) == TO - 1) begin
                nm = 0;
            end else if (en) begin
                nm = mode + 1;
            end else begin
                if (ei || ed) act_ref = t + 1;
                if (ei) inc_press = t; else if (!btn_inc) inc_press = -1;
                if (ed) dec_press = t; else if (!btn_dec) dec_press = -1;
                fi = (inc_press >= 0) && rep_hit(t - inc_press);
                fd = (dec_press >= 0) && rep_hit(t - dec_press);
                if ((fi && !btn_dec) || (fd && !btn_inc)) begin
                    if (mode == 1) mh = bump(mh, 24, fi);
                    else           mm = bump(mm, 60, fi);
                    blink_ref = t + 1;
                end
            end
            if (nm != mode && (nm == 1 || nm == 2)) begin
                blink_ref = t + 1; act_ref = t + 1;
                inc_press = -1; dec_press = -1;
            end
            mode = nm;
            p_next = btn_next; p_inc = btn_inc; p_dec = btn_dec;
            eblank = 0;
            if (((t + 1 - blink_ref) % (2 * BH)) >= BH) begin
                if (mode == 1) eblank = 6'b000011;
                if (mode == 2) eblank = 6'b001100;
            end
        end
        eh = mh; em = mm;
        eedit = (mode != 0);
        ecommit = (mode == 3);
        t++;
    end

    always @(negedge clk) begin
        chk("hours", int'(hours), eh);
        chk("minutes", int'(minutes), em);
        chk("blank", int'(blank), eblank);
        chk("editing", int'(editing), eedit);
        chk("commit", int'(commit), ecommit);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req();
        set_req = 1'b1; tick(); set_req = 1'b0;
    endtask

    // which: 0 next, 1 inc, 2 dec
    task automatic press(input int which);
        case (which)
            0: btn_next = 1'b1;
            1: btn_inc = 1'b1;
            default: btn_dec = 1'b1;
        endcase
        tick();
        btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; set_req = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_hours = 5'd0; cur_minutes = 6'd0;
        tick(); tick();
        chk("rst_hours", int'(hours), 0);
        chk("rst_editing", int'(editing), 0);
        reset = 1'b0;

        // Basic edit 13:45 -> 15:44
        cur_hours = 5'd13; cur_minutes = 6'd45; tick();
        chk("idle_track", int'(hours), 13);
        req();
        chk("snap_edit", int'(editing), 1);
        chk("snap_min", int'(minutes), 45);
        press(1); press(1);
        chk("inc2", int'(hours), 15);
        press(0); press(2);
        chk("dec1", int'(minutes), 44);
        btn_next = 1'b1; tick();
        chk("commit_pulse", int'(commit), 1);
        chk("commit_h", int'(hours), 15);
        chk("commit_m", int'(minutes), 44);
        btn_next = 1'b0; tick();
        chk("commit_end", int'(commit), 0);
        chk("post_commit_edit", int'(editing), 0);
        cur_hours = 5'd8; cur_minutes = 6'd30; tick(); tick();
        chk("retrack_h", int'(hours), 8);

        // Wraps at 23:59
        cur_hours = 5'd23; cur_minutes = 6'd59; tick();
        req();
        press(1); chk("wrap_h_up", int'(hours), 0);
        press(2); chk("wrap_h_dn", int'(hours), 23);
        press(0);
        press(1); chk("wrap_m_up", int'(minutes), 0);
        press(2); chk("wrap_m_dn", int'(minutes), 59);
        req();
        chk("abort_edit", int'(editing), 0);
        chk("abort_commit", int'(commit), 0);

        // Auto-repeat in minute field
        cur_hours = 5'd5; cur_minutes = 6'd10; tick();
        req(); press(0);
        btn_inc = 1'b1;
        repeat (13) tick();
        btn_inc = 1'b0; tick();
        chk("repeat_min", int'(minutes), 15);
        req();

        // Blink pattern
        cur_hours = 5'd1; cur_minutes = 6'd2; tick();
        req();
        repeat (3) tick(); chk("blink_h_vis", int'(blank), 0);
        tick();            chk("blink_h_off", int'(blank), 3);
        repeat (4) tick(); chk("blink_h_back", int'(blank), 0);
        btn_next = 1'b1; tick(); btn_next = 1'b0;
        repeat (3) tick(); chk("blink_m_vis", int'(blank), 0);
        tick();            chk("blink_m_off", int'(blank), 12);
        req();

        // Timeout in hour field
        tick(); req();
        repeat (39) tick(); chk("to_before", int'(editing), 1);
        tick();             chk("to_after", int'(editing), 0);
        tick();

        // Reset mid-edit
        req(); press(1);
        reset = 1'b1; tick();
        chk("rst_mid_h", int'(hours), 0);
        chk("rst_mid_edit", int'(editing), 0);
        reset = 1'b0; tick();

        // Conflicts
        req();
        btn_inc = 1'b1; btn_dec = 1'b1;
        repeat (8) tick();
        btn_inc = 1'b0; btn_dec = 1'b0; tick();
        chk("both_held", int'(hours), 1);
        req();
        cur_hours = 5'd27; tick();
        chk("raw_track", int'(hours), 27);
        req(); chk("snap_sanitize", int'(hours), 0);
        req();
        cur_hours = 5'd4; cur_minutes = 6'd20;
        btn_next = 1'b1; tick(); tick();
        req(); tick(); tick();
        btn_inc = 1'b1; tick(); btn_inc = 1'b0; tick();
        chk("held_next_h", int'(hours), 5);
        chk("held_next_m", int'(minutes), 20);
        btn_next = 1'b0; tick();
        press(0); press(2);
        chk("after_repress", int'(minutes), 19);
        req(); tick();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 599) == 0);
            set_req = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 9) == 0)  btn_inc = ~btn_inc;
            if ($urandom_range(0, 9) == 0)  btn_dec = ~btn_dec;
            if ($urandom_range(0, 3) == 0) begin
                cur_hours   = 5'($urandom_range(0, 25));
                cur_minutes = 6'($urandom_range(0, 61));
            end
            tick();
        end
        reset = 1'b0; set_req = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
